add_result_acc: RTL and testbench
=================================

Name: add_result_acc

Overview:
- Downstream consumer of the adder output stream: 10-bit sum plus valid, one sum per valid cycle, no backpressure toward the adder.
- Accumulates consecutive valid sums into groups of GROUP_LEN and emits each group total with its sample count and an overflow flag.
- Results are buffered in a small FIFO and drained by a ready/valid handshake toward the scoreboard/host side.

Parameters:
- GROUP_LEN, 8: samples per group; legal range 2..255.
- ACC_W, 16: accumulator and result width in bits; legal range >= 10.
- FIFO_DEPTH, 4: result FIFO entries; must be a power of 2, >= 2.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset, synchronous and active-low.
- in_data  input  10  sum from the adder.
- in_valid  input  1  in_data valid this cycle; no ready exists.
- flush  input  1  close the current partial group.
- out_data  output  ACC_W  group total.
- out_cnt  output  8  number of samples in the group.
- out_ovf  output  1  group total saturated.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts the FIFO head.
- drop  output  1  sticky: a group result was lost because the FIFO was full.

Behaviour:
- Reset (rst_n=0 at posedge):
  - Accumulator, sample count, ovf bit, FIFO pointers and drop cleared.
  - out_valid=0, out_data=0, out_cnt=0, out_ovf=0.
  - Reset mid-group discards the partial group; reset with FIFO entries discards those entries.
- Accumulate:
  - Each posedge with in_valid=1 adds zero-extended in_data to acc and increments cnt.
  - Arithmetic is ACC_W+1 bits wide. If the result exceeds 2^ACC_W-1, acc is held at all-ones and ovf is set for the rest of the group.
- Group close: a group closes on the posedge where either of the following holds.
  - (a) in_valid=1 and cnt reaches GROUP_LEN with this sample.
  - (b) flush=1 and the group, including any sample accepted on the same edge, has cnt>=1.
  - flush with an empty group and in_valid=0 is ignored: no push.
  - flush and in_valid on the same edge: the sample is included, then the group closes.
- Push on close:
  - Pushed value is {final acc, final cnt, ovf}.
  - acc, cnt and ovf restart at 0 on the same edge, so the next sample starts a new group with no gap cycle.
- FIFO:
  - out_* is driven from the entry at the read pointer.
  - out_valid = not empty, so a pushed result is visible in the cycle after the closing edge (latency 1 cycle from the last sample edge).
  - Pop occurs when out_valid && out_ready at a posedge.
  - out_data, out_cnt and out_ovf must hold stable while out_valid=1 and out_ready=0.
  - When empty, out_* hold their last value; the consumer must ignore them.
- Full conditions:
  - Push while full with a pop on the same edge: accepted; occupancy unchanged.
  - Push while full with no pop: the result is discarded and drop is set (sticky until reset). Accumulator restart still occurs.
- Pointers wrap modulo FIFO_DEPTH. Full/empty use an extra pointer bit.
- out_ready while empty has no effect.

Optional Feature:
- ACC_DROP_CNT_EN defined:
  - Adds output port drop_cnt, 8 bits, reset 0.
  - drop_cnt increments on every discarded result and saturates at 255.
  - drop behaves as above.
- ACC_DROP_CNT_EN undefined:
  - Port drop_cnt and its counter do not exist; only the sticky drop flag is present.

Test Plan:
- GROUP_LEN=4, out_ready=1, in_data 1,2,3,4 on consecutive cycles -> one cycle after the 4th edge: out_valid=1, out_data=10, out_cnt=4, out_ovf=0; next group starts clean.
- ACC_W=10, GROUP_LEN=4, in_data=1022 four times -> out_data=1023, out_ovf=1, out_cnt=4.
- GROUP_LEN=8, in_data 5 then 7, then flush with in_valid=0 -> out_data=12, out_cnt=2. Then flush with in_valid=1, in_data=9 -> out_data=9, out_cnt=1. Then flush alone -> no push.
- FIFO_DEPTH=4, out_ready=0, five groups of 4x in_data=1 -> four entries of out_data=4; fifth result discarded; drop=1; drop_cnt=1 with ACC_DROP_CNT_EN. Then out_ready=1 -> exactly 4 pops with stable data while stalled.
- FIFO full, fifth group closes on the same edge as a pop -> no drop; occupancy stays 4; entries drain in order.
- rst_n=0 for one cycle after 3 of 4 samples (1,1,1) with 2 FIFO entries -> out_valid=0 next cycle, drop=0. Following samples 2,2,2,2 -> out_data=8, out_cnt=4.

Source files
------------

// File: rtl/add_result_acc.sv
// Groups consecutive adder sums into GROUP_LEN-sample totals and queues them in a small ready/valid FIFO.
// Optional ACC_DROP_CNT_EN adds a saturating count of discarded results on port drop_cnt.
module add_result_acc #(
    parameter int GROUP_LEN  = 8,
    parameter int ACC_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       in_data,
    input  logic             in_valid,
    input  logic             flush,
    output logic [ACC_W-1:0] out_data,
    output logic [7:0]       out_cnt,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             drop
`ifdef ACC_DROP_CNT_EN
    ,
    output logic [7:0]       drop_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = ACC_W + 9;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             drop_q, drop_d;
    logic [EW-1:0]    head_q, head_d;
    logic [EW-1:0]    mem [FIFO_DEPTH];

    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_s;
    logic [7:0]       cnt_s;
    logic             ovf_s;
    logic             close, empty, full, pop, push_ok, discard;
    logic [EW-1:0]    push_entry;

    always_comb begin
        sum   = {1'b0, acc_q} + {{(ACC_W-9){1'b0}}, in_data};
        acc_s = acc_q;
        cnt_s = cnt_q;
        ovf_s = ovf_q;
        if (in_valid) begin
            cnt_s = cnt_q + 8'd1;
            if (sum[ACC_W]) begin
                acc_s = '1;
                ovf_s = 1'b1;
            end else begin
                acc_s = sum[ACC_W-1:0];
            end
        end
        // The group state after this edge's sample decides the close, so flush+sample closes with the sample included.
        close      = (in_valid && cnt_s == 8'(GROUP_LEN)) || (flush && cnt_s != 8'd0);
        push_entry = {acc_s, cnt_s, ovf_s};

        empty   = (wr_q == rd_q);
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop     = !empty && out_ready;
        push_ok = close && (!full || pop);
        discard = close && full && !pop;

        acc_d  = close ? '0    : acc_s;
        cnt_d  = close ? 8'd0  : cnt_s;
        ovf_d  = close ? 1'b0  : ovf_s;
        wr_d   = wr_q + (AW+1)'(push_ok);
        rd_d   = rd_q + (AW+1)'(pop);
        drop_d = drop_q | discard;

        // Head register tracks the entry at the next read pointer; forward the new entry when it becomes the head.
        head_d = head_q;
        if (wr_d != rd_d) begin
            if (push_ok && rd_d == wr_q) head_d = push_entry;
            else                         head_d = mem[rd_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            wr_q   <= '0;
            rd_q   <= '0;
            drop_q <= 1'b0;
            head_q <= '0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            drop_q <= drop_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_ok) mem[wr_q[AW-1:0]] <= push_entry;
    end

    assign out_data  = head_q[EW-1 -: ACC_W];
    assign out_cnt   = head_q[8:1];
    assign out_ovf   = head_q[0];
    assign out_valid = !empty;
    assign drop      = drop_q;

`ifdef ACC_DROP_CNT_EN
    logic [7:0] dcnt_q, dcnt_d;

    always_comb begin
        dcnt_d = dcnt_q;
        if (discard && dcnt_q != 8'hFF) dcnt_d = dcnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) dcnt_q <= '0;
        else        dcnt_q <= dcnt_d;
    end

    assign drop_cnt = dcnt_q;
`endif

endmodule

// File: tb/tb_add_result_acc.sv
// Directed plus randomized check of add_result_acc against a queue-based reference model.
module tb_add_result_acc;

    localparam int GL      = 4;
    localparam int AW_ACC  = 10;
    localparam int DEPTH   = 4;
    localparam int ACC_MAX = (1 << AW_ACC) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [9:0]        in_data;
    logic              in_valid;
    logic              flush;
    logic [AW_ACC-1:0] out_data;
    logic [7:0]        out_cnt;
    logic              out_ovf;
    logic              out_valid;
    logic              out_ready;
    logic              drop;
`ifdef ACC_DROP_CNT_EN
    logic [7:0]        drop_cnt;
`endif

    always #5 clk = ~clk;

    add_result_acc #(.GROUP_LEN(GL), .ACC_W(AW_ACC), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .flush    (flush),
        .out_data (out_data),
        .out_cnt  (out_cnt),
        .out_ovf  (out_ovf),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .drop     (drop)
`ifdef ACC_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    typedef struct {
        int data;
        int cnt;
        bit ovf;
    } res_t;

    res_t q[$];
    int   m_acc, m_cnt, m_dcnt;
    bit   m_ovf, m_drop;
    int   compared   = 0;
    int   mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_data", 32'(out_data), q[0].data);
            chk("out_cnt",  32'(out_cnt),  q[0].cnt);
            chk("out_ovf",  32'(out_ovf),  32'(q[0].ovf));
        end
        chk("drop", 32'(drop), 32'(m_drop));
`ifdef ACC_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), m_dcnt);
`endif
    endtask

    task automatic step(input bit v, input int d, input bit f, input bit r);
        bit   pop, was_full, close;
        res_t e;
        in_valid  = v;
        in_data   = d[9:0];
        flush     = f;
        out_ready = r;
        pop      = (q.size() > 0) && r;
        was_full = (q.size() == DEPTH);
        if (v) begin
            m_acc += d;
            m_cnt++;
            if (m_acc > ACC_MAX) begin
                m_acc = ACC_MAX;
                m_ovf = 1'b1;
            end
        end
        close = (v && m_cnt == GL) || (f && m_cnt >= 1);
        if (pop) void'(q.pop_front());
        if (close) begin
            if (!was_full || pop) begin
                e.data = m_acc;
                e.cnt  = m_cnt;
                e.ovf  = m_ovf;
                q.push_back(e);
            end else begin
                m_drop = 1'b1;
                if (m_dcnt < 255) m_dcnt++;
            end
            m_acc = 0;
            m_cnt = 0;
            m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
        $display("step v=%0d d=%0d f=%0d r=%0d -> valid=%0d data=%0d cnt=%0d ovf=%0d drop=%0d",
                 v, d, f, r, out_valid, out_data, out_cnt, out_ovf, drop);
        check_outputs();
    endtask

    task automatic do_reset(input int n);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        m_acc  = 0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_drop = 1'b0;
        m_dcnt = 0;
        $display("reset %0d cycle(s) -> valid=%0d data=%0d cnt=%0d ovf=%0d drop=%0d",
                 n, out_valid, out_data, out_cnt, out_ovf, drop);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data",  32'(out_data),  0);
        chk("rst_cnt",   32'(out_cnt),   0);
        chk("rst_ovf",   32'(out_ovf),   0);
        chk("rst_drop",  32'(drop),      0);
`ifdef ACC_DROP_CNT_EN
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
`endif
    endtask

    initial begin
        do_reset(2);

        // Basic group of four
        for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b1);
        chk("t1_data", 32'(out_data), 10);
        chk("t1_cnt",  32'(out_cnt),  4);
        chk("t1_ovf",  32'(out_ovf),  0);
        step(1'b0, 0, 1'b0, 1'b1);

        // Saturation
        for (int i = 0; i < 4; i++) step(1'b1, 1022, 1'b0, 1'b1);
        chk("t2_data", 32'(out_data), 1023);
        chk("t2_ovf",  32'(out_ovf),  1);
        chk("t2_cnt",  32'(out_cnt),  4);
        step(1'b0, 0, 1'b0, 1'b1);

        // Flush variants
        step(1'b1, 5, 1'b0, 1'b1);
        step(1'b1, 7, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        chk("t3_data", 32'(out_data), 12);
        chk("t3_cnt",  32'(out_cnt),  2);
        step(1'b1, 9, 1'b1, 1'b1);
        chk("t3b_data", 32'(out_data), 9);
        chk("t3b_cnt",  32'(out_cnt),  1);
        step(1'b0, 0, 1'b1, 1'b1);
        chk("t3c_novalid", 32'(out_valid), 0);

        // Fill FIFO with stalled consumer, fifth result dropped, then drain
        for (int g = 0; g < 5; g++)
            for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b0, 1'b0);
        chk("t4_drop", 32'(drop), 1);
        chk("t4_data", 32'(out_data), 4);
`ifdef ACC_DROP_CNT_EN
        chk("t4_drop_cnt", 32'(drop_cnt), 1);
`endif
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0, 1'b1);
        chk("t4_empty", 32'(out_valid), 0);

        // Push on a full FIFO coinciding with a pop
        do_reset(1);
        for (int i = 0; i < 19; i++) step(1'b1, 1, 1'b0, 1'b0);
        step(1'b1, 1, 1'b0, 1'b1);
        chk("t5_nodrop", 32'(drop), 0);
        chk("t5_occ", 32'(q.size()), 4);
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b0, 1'b1);

        // Reset mid-group with FIFO entries pending
        do_reset(1);
        for (int i = 0; i < 11; i++) step(1'b1, 1, 1'b0, 1'b0);
        do_reset(1);
        for (int i = 0; i < 4; i++) step(1'b1, 2, 1'b0, 1'b0);
        chk("t6_data", 32'(out_data), 8);
        chk("t6_cnt",  32'(out_cnt),  4);
        for (int i = 0; i < 2; i++) step(1'b0, 0, 1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit v, f, r;
            int d;
            if (i == 300) do_reset(2);
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 60));
            f = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 2) != 0);
            step(v, d, f, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
